mul_sequencer: RTL
==================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle radix-2 shift-add multiplier with start/done handshake.
//  Replaces the combinational IMUL array in the MiniAlu datapath.
//  Issues a stall to freeze the IP and operand FFDs while a product is computed.
//  The ALU writes oResult to RAM in the single oDone cycle.
// PARAMETERS
//  WIDTH  8  operand width; the product is 2*WIDTH bits
// PORTS
//  Clock    in   1        system clock; all state updates on posedge
//  Reset    in   1        asynchronous, active-high; clears all state
//  iStart   in   1        IMUL decoded (level); sampled only in IDLE
//  iA       in   WIDTH    multiplicand (wSourceData1[WIDTH-1:0])
//  iB       in   WIDTH    multiplier   (wSourceData0[WIDTH-1:0])
//  oStall   out  1        freeze IP/FFDs; combinational
//  oBusy    out  1        high while state==RUN
//  oDone    out  1        one-cycle strobe; result valid, ALU asserts write enable
//  oResult  out  2*WIDTH  product; held until next accepted start
// BEHAVIOUR
//  Reset values: state=IDLE; oBusy=0, oDone=0, oResult=0; internal regs 0.
//  FSM states, encoded in 2 bits:
//   IDLE -> RUN  when iStart=1. Load rMcand={WIDTH'0,iA}, rMplr=iB, rAcc=0, rCnt=WIDTH.
//   RUN  -> RUN  on each edge: if rMplr[0], rAcc+=rMcand; then rMcand<<=1, rMplr>>=1, rCnt-=1.
//   RUN  -> DONE on the edge where rCnt==1. That edge performs the final add.
//               oResult <= final rAcc.
//   DONE -> IDLE always. iStart is ignored in DONE.
//  Latency: start is accepted at edge 0; oDone is high for the cycle after edge WIDTH.
//   For WIDTH=8 this is 8 RUN cycles plus 1 DONE cycle.
//  oStall = (state==RUN) | (state==IDLE & iStart). It is low in DONE, so the IP advances
//   exactly as the result is written.
//  Because iStart is ignored in DONE, the held IMUL cannot retrigger.
//   A following IMUL is decoded the next cycle, in IDLE.
//  Arithmetic is unsigned. No overflow is possible: rAcc is 2*WIDTH bits.
//   rMcand shifts within 2*WIDTH bits; shifted-out bits are dropped (never set).
//  iA and iB are sampled only at accept; changes during RUN are ignored.
//  Reset mid-operation: an immediate return to IDLE. The partial product is discarded,
//   oDone is never pulsed, and oResult=0.
//  Operand 0 or 1: no special path (except with the option below). Latency is unchanged.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined:
//   RUN -> DONE also when the post-shift rMplr==0, i.e. no remaining 1 bits.
//   Latency is then (index of MSB set in iB)+1 RUN cycles, minimum 1 (iB=0 gives 1 cycle).
//  MUL_EARLY_EXIT_EN undefined: fixed WIDTH-cycle latency, as above.
// STRUCTURE
//  The shared definitions include holds:
//   - the state encodings MS_IDLE=2'd0, MS_RUN=2'd1, MS_DONE=2'd2;
//   - the IMUL opcode `define, so the decoder and this block agree.
//  One sub-module: mul_iter_counter, a loadable down-counter.
//   Inputs: Clock, async Reset, Load, LoadValue=WIDTH, Enable.
//   It outputs rCnt and a Last flag (rCnt==1).
//  The datapath registers (rMcand, rMplr, rAcc) and the FSM stay in mul_sequencer.
// TESTING
//  1 iA=13, iB=11, iStart held -> oStall high 9 cycles (1 IDLE + 8 RUN);
//     oDone for 1 cycle with oResult=16'h008F; oStall=0 in that cycle.
//  2 iA=255, iB=255 -> oResult=16'hFE01 after 8 RUN cycles; oBusy=1 exactly 8 cycles.
//  3 iA=200, iB=0 -> oResult=0. With MUL_EARLY_EXIT_EN, oDone comes after 1 RUN cycle;
//     without it, after 8. Also iB=3 with EN: oDone after 2 RUN cycles.
//  4 Start iA=7, iB=6. Change iA/iB to 9/9 at RUN cycle 3 -> oResult=42 (16'h002A).
//     iStart held through DONE -> no second run; state is IDLE next cycle.
//  5 Reset pulsed asynchronously (mid-cycle) during RUN cycle 4
//     -> oBusy, oDone and oResult are 0 immediately; no oDone strobe follows.
//     A later start of 3*5 gives 15.
//  6 Back-to-back: 5*5, then 4*4 decoded the cycle after oDone -> two oDone strobes.
//     Results are 25 then 16, with exactly 1 IDLE cycle between the runs.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier.
// Optional feature macro: MUL_EARLY_EXIT_EN (see mul_sequencer.sv).

// IMUL opcode, shared with the MiniAlu decoder so both sides agree.
`ifndef MUL_OP_IMUL
`define MUL_OP_IMUL 4'd9
`endif

package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam int MUL_WIDTH_DEF = 8;

  // Counter width able to hold the value WIDTH itself.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_if.sv
// Start/done handshake bundle between the ALU and the multiplier.
interface mul_if #(
  parameter int WIDTH = 8
);
  logic               iStart;
  logic [WIDTH-1:0]   iA;
  logic [WIDTH-1:0]   iB;
  logic               oStall;
  logic               oBusy;
  logic               oDone;
  logic [2*WIDTH-1:0] oResult;

  modport master (output iStart, iA, iB, input oStall, oBusy, oDone, oResult);
  modport slave  (input iStart, iA, iB, output oStall, oBusy, oDone, oResult);
endinterface

// File: rtl/mul_iter_counter.sv
// Loadable down-counter tracking remaining shift-add iterations.
module mul_iter_counter
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW   = cnt_bits(WIDTH)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_value_i,
  input  logic          enable_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)        cnt_d = load_value_i;
    else if (enable_i) cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(1));
endmodule

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier sequencer with stall/start/done handshake.
// Define MUL_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF,
  localparam int CW   = cnt_bits(WIDTH)
) (
  input logic  Clock,
  input logic  Reset,
  mul_if.slave bus
);
  ms_state_e          state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d, mplr_sh;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               cnt_load, cnt_en, cnt_last, early;
  logic [CW-1:0]      cnt;

  mul_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .Clock       (Clock),
    .Reset       (Reset),
    .load_i      (cnt_load),
    .load_value_i(CW'(WIDTH)),
    .enable_i    (cnt_en),
    .cnt_o       (cnt),
    .last_o      (cnt_last)
  );

  assign mplr_sh = mplr_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
  assign early = (mplr_sh == '0);
`else
  assign early = 1'b0;
`endif

  // Next-state and datapath update; operands are captured only on accept.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      MS_IDLE: if (bus.iStart) begin
        state_d  = MS_RUN;
        mcand_d  = {{WIDTH{1'b0}}, bus.iA};
        mplr_d   = bus.iB;
        acc_d    = '0;
        cnt_load = 1'b1;
      end
      MS_RUN: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_sh;
        cnt_en  = 1'b1;
        if (cnt_last || early) begin
          state_d  = MS_DONE;
          result_d = acc_d;
        end
      end
      // iStart is ignored here so a held IMUL cannot retrigger.
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= MS_IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // The counter is never zero while iterating.
  a_cnt_live: assert property (@(posedge Clock) disable iff (Reset)
    (state_q == MS_RUN) |-> (cnt != '0));

  // Stall drops in DONE so the IP advances as the result is written.
  assign bus.oStall  = (state_q == MS_RUN) || ((state_q == MS_IDLE) && bus.iStart);
  assign bus.oBusy   = (state_q == MS_RUN);
  assign bus.oDone   = (state_q == MS_DONE);
  assign bus.oResult = result_q;
endmodule
